// File: rtl/synth_mem_pkg.sv
// Shared widths, latency limit and response record for the synth core memory model.
package synth_mem_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ADDR_W_DEF     = 10;
    localparam int MAX_RD_LATENCY = 4;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Stallable read-response shift register, STAGES deep, cleared synchronously by clr.
module mem_rsp_pipe
    import synth_mem_pkg::*;
#(
    parameter int  STAGES = 1,
    parameter type rsp_t  = mem_rsp_t
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  rsp_t din,
    output rsp_t dout
);

    rsp_t stage_q [STAGES];
    rsp_t stage_d [STAGES];

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/synth_mem_model.sv
// Cycle-accurate program/data memory with read latency pipeline, stall, range checks and counters.
// Optional program-region write protection is enabled by defining MEM_WRPROTECT_EN.
module synth_mem_model
    import synth_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16,
    parameter int WP_TOP     = 64
) (
    input  logic              clk_io,
    input  logic              reset_io,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    input  logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int LAT   = (RD_LATENCY < 1) ? 1 :
                           (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] WP_TOP_L = (ADDR_W+1)'(WP_TOP);
`ifdef MEM_WRPROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic             in_range;
    logic             wp_hit;
    logic             accept;
    logic             rd_acc;
    logic             wr_commit;
    logic             wr_drop;
    logic [IDX_W-1:0] idx;
    logic             pipe_en;
    rsp_t             pipe_in;
    rsp_t             pipe_out;

    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             wr_err_q, wr_err_d;

    always_comb begin
        req_ready = !stall && !reset_io;
        accept    = req_valid && req_ready;
        in_range  = {1'b0, req_addr} < DEPTH_L;
        wp_hit    = WP_EN && ({1'b0, req_addr} < WP_TOP_L);
        idx       = req_addr[IDX_W-1:0];
        rd_acc    = accept && !req_we;
        wr_commit = accept && req_we && in_range && !wp_hit;
        wr_drop   = accept && req_we && !(in_range && !wp_hit);
        pipe_en   = !stall;

        // Out-of-range reads travel the same pipeline with zero data and err set.
        pipe_in       = '0;
        pipe_in.valid = rd_acc;
        pipe_in.err   = rd_acc && !in_range;
        if (rd_acc && in_range) begin
            pipe_in.data = mem[idx];
        end

        rd_count_d = rd_acc    ? sat_inc(rd_count_q) : rd_count_q;
        wr_count_d = wr_commit ? sat_inc(wr_count_q) : wr_count_q;
        wr_err_d   = wr_drop;
    end

    always_ff @(posedge clk_io) begin
        if (wr_commit) begin
            mem[idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk_io) begin
        if (reset_io) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            wr_err_q   <= wr_err_d;
        end
    end

    mem_rsp_pipe #(
        .STAGES (LAT),
        .rsp_t  (rsp_t)
    ) u_rsp_pipe (
        .clk  (clk_io),
        .clr  (reset_io),
        .en   (pipe_en),
        .din  (pipe_in),
        .dout (pipe_out)
    );

    assign rsp_valid = pipe_out.valid;
    assign rsp_err   = pipe_out.err;
    assign rsp_rdata = pipe_out.data;
    assign wr_err    = wr_err_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule
